do_tan_so_ena: RTL and testbench

Enable-pulse frequency meter: the receiving end of the divided-enable chain. It counts rising edges of one `ckht`-synchronous enable stream over a fixed gate window and reports the measured rate in pulses per window. It also classifies the rate back to the 2-bit channel code of the 4-channel selector (1/20/50/100 Hz). It sits beside the clock-divider/selector pair and lets the design confirm which enable rate is actually being driven.

---
 rtl/do_tan_so_ena_if.sv | 16 +
 rtl/do_tan_so_ena.sv | 134 +++++++++++++
 tb/tb_do_tan_so_ena.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/do_tan_so_ena_if.sv
// Bus bundle for the enable-pulse frequency meter: run/stimulus toward the meter,
// measurement results (freq, valid, ovf, sw_code, match) back from it.
interface do_tan_so_ena_if #(
    parameter int CNT_W = 10
);
    logic             run;
    logic             ena_in;
    logic [CNT_W-1:0] freq;
    logic             valid;
    logic             ovf;
    logic [1:0]       sw_code;
    logic             match;

    modport master (output run, ena_in, input  freq, valid, ovf, sw_code, match);
    modport slave  (input  run, ena_in, output freq, valid, ovf, sw_code, match);
endinterface

// File: rtl/do_tan_so_ena.sv
// Enable-pulse frequency meter: counts ena_in rising edges per gate window and classifies the rate.
// Optional classification (sw_code/match) is built only when DO_TAN_SO_CLASSIFY_EN is defined.
module do_tan_so_ena #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 10,
    parameter int TOL         = 1
) (
    input  logic           ckht,
    input  logic           rst_n,
    do_tan_so_ena_if.slave bus
);
    localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (GATE_CYCLES < 2 || TOL < 0 || CNT_W < 1 || CNT_W > 31) begin : g_bad_params
        $error("do_tan_so_ena: unsupported parameter set");
    end

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state, state_nx;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sat_q, sat_d, sat_inc;
    logic             ena_d;
    logic             edge_seen;
    logic             load;

    assign edge_seen = bus.ena_in & ~ena_d;

    // Count and saturation flag as they stand after this cycle's edge, so an
    // edge on the last gate cycle still lands in the window being closed.
    assign cnt_inc = (edge_seen && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    assign sat_inc = sat_q | (edge_seen & (cnt_q == CNT_MAX));

    always_comb begin
        // NOTE: every signal gets a default before the case, otherwise a missed branch infers a latch.
        state_nx = state;
        gate_d   = gate_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        load     = 1'b0;
        case (state)
            IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                sat_d  = 1'b0;
                if (bus.run) state_nx = MEASURE;
            end
            MEASURE: begin
                if (!bus.run) begin
                    // Abort wins over a coinciding end of window.
                    state_nx = IDLE;
                    gate_d   = '0;
                    cnt_d    = '0;
                    sat_d    = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    load   = 1'b1;
                    gate_d = '0;
                    cnt_d  = '0;
                    sat_d  = 1'b0;
                end else begin
                    gate_d = gate_q + GW'(1);
                    cnt_d  = cnt_inc;
                    sat_d  = sat_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gate_q    <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            ena_d     <= 1'b0;
            bus.freq  <= '0;
            bus.ovf   <= 1'b0;
            bus.valid <= 1'b0;
        end else begin
            state     <= state_nx;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            ena_d     <= bus.ena_in;
            bus.valid <= load;
            if (load) begin
                bus.freq <= cnt_inc;
                bus.ovf  <= sat_inc;
            end
        end
    end

`ifdef DO_TAN_SO_CLASSIFY_EN
    logic [31:0] f32, nominal, dev;
    logic [1:0]  code_nx;
    logic        match_nx;

    always_comb begin
        f32     = 32'(cnt_inc);
        code_nx = 2'b11;
        nominal = 32'd100;
        if (f32 < 32'd11) begin
            code_nx = 2'b00;
            nominal = 32'd1;
        end else if (f32 < 32'd35) begin
            code_nx = 2'b01;
            nominal = 32'd20;
        end else if (f32 < 32'd75) begin
            code_nx = 2'b10;
            nominal = 32'd50;
        end
        dev      = (f32 >= nominal) ? f32 - nominal : nominal - f32;
        match_nx = (dev <= 32'(TOL));
    end

    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            bus.sw_code <= 2'b00;
            bus.match   <= 1'b0;
        end else if (load) begin
            bus.sw_code <= code_nx;
            bus.match   <= match_nx;
        end
    end
`else
    assign bus.sw_code = 2'b00;
    assign bus.match   = 1'b0;
`endif
endmodule

// File: tb/tb_do_tan_so_ena.sv
// Bench for do_tan_so_ena: two meters (10-bit and 4-bit counters) share one stimulus
// stream and are compared window by window against an edge-counting reference model.
module tb_do_tan_so_ena;
    localparam int G   = 1000;
    localparam int TOL = 1;

    localparam int MODE_PERIOD = 0;
    localparam int MODE_HIGH   = 1;
    localparam int MODE_RAND   = 2;
    localparam int MODE_COUNT  = 3;

    logic ckht   = 1'b0;
    logic rst_n  = 1'b1;
    logic run    = 1'b0;
    logic ena_in = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    bit          prev_ena  = 1'b0;
    bit          measuring = 1'b0;
    logic [27:0] last_exp  = '0;

    always #5 ckht = ~ckht;

    do_tan_so_ena_if #(.CNT_W(10)) bus10 ();
    do_tan_so_ena_if #(.CNT_W(4))  bus4 ();

    assign bus10.run    = run;
    assign bus10.ena_in = ena_in;
    assign bus4.run     = run;
    assign bus4.ena_in  = ena_in;

    do_tan_so_ena #(.GATE_CYCLES(G), .CNT_W(10), .TOL(TOL)) u_dut10 (
        .ckht (ckht),
        .rst_n(rst_n),
        .bus  (bus10.slave)
    );

    do_tan_so_ena #(.GATE_CYCLES(G), .CNT_W(4), .TOL(TOL)) u_dut4 (
        .ckht (ckht),
        .rst_n(rst_n),
        .bus  (bus4.slave)
    );

    wire [13:0] obs10 = {bus10.freq, bus10.ovf, bus10.sw_code, bus10.match};
    wire [13:0] obs4  = {6'b0, bus4.freq, bus4.ovf, bus4.sw_code, bus4.match};
    wire [27:0] obs   = {obs10, obs4};

    // Expected {freq, ovf, sw_code, match} of a w-bit meter after a window with 'edges' rising edges.
    function automatic logic [13:0] model(input int edges, input int w);
        int         maxv;
        int         f;
        bit         ov;
        logic [1:0] code;
        bit         m;
`ifdef DO_TAN_SO_CLASSIFY_EN
        int         nom;
        int         dev;
`endif
        maxv = (1 << w) - 1;
        f    = (edges > maxv) ? maxv : edges;
        ov   = (edges > maxv);
        code = 2'b00;
        m    = 1'b0;
`ifdef DO_TAN_SO_CLASSIFY_EN
        if (f < 11)      begin code = 2'b00; nom = 1;   end
        else if (f < 35) begin code = 2'b01; nom = 20;  end
        else if (f < 75) begin code = 2'b10; nom = 50;  end
        else             begin code = 2'b11; nom = 100; end
        dev = f - nom;
        if (dev < 0) dev = -dev;
        m = (dev <= TOL);
`endif
        return {10'(f), ov, code, m};
    endfunction

    function automatic logic [27:0] model_pair(input int edges);
        return {model(edges, 10), model(edges, 4)};
    endfunction

    task automatic start_measure();
        if (!measuring) begin
            run      = 1'b1;
            ena_in   = 1'b0;
            prev_ena = 1'b0;
            @(posedge ckht);
            #1;
            measuring = 1'b1;
        end
    endtask

    // Drives 'len' cycles with run=1; counts rising edges of the driven stream and
    // records any valid seen before the last gate cycle plus the valid after it.
    task automatic run_window(input int mode, input int prm, input int len,
                              output int edges, output int early, output bit last_valid);
        int phase;
        bit e;
        phase      = (mode == MODE_PERIOD) ? $urandom_range(prm - 1, 0) : 0;
        edges      = 0;
        early      = 0;
        last_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            case (mode)
                MODE_PERIOD: e = ((i % prm) == phase);
                MODE_HIGH:   e = 1'b1;
                MODE_RAND:   e = ($urandom_range(99, 0) < prm);
                default:     e = ((i % 7) == 3) && ((i / 7) < prm);
            endcase
            if (e && !prev_ena) edges++;
            prev_ena = e;
            run      = 1'b1;
            ena_in   = e;
            @(posedge ckht);
            #1;
            if (i == G - 1) last_valid = bus10.valid & bus4.valid;
            else if (bus10.valid || bus4.valid) early++;
        end
    endtask

    task automatic idle_cycles(input int n, output int valids);
        bit e;
        valids = 0;
        for (int i = 0; i < n; i++) begin
            e        = $urandom_range(1, 0) == 1;
            run      = 1'b0;
            ena_in   = e;
            prev_ena = e;
            @(posedge ckht);
            #1;
            if (bus10.valid || bus4.valid) valids++;
        end
        measuring = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge ckht);
        #1;
        n_cmp++;
        if ({obs, bus10.valid, bus4.valid} !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", {obs, bus10.valid, bus4.valid}, 30'd0);
        end
        rst_n    = 1'b1;
        prev_ena = 1'b0;
        @(posedge ckht);
        #1;
        n_cmp++;
        if ({obs, bus10.valid, bus4.valid} !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got %h expected %h", {obs, bus10.valid, bus4.valid}, 30'd0);
        end
    endtask

    task automatic test_held_high();
        int edges, early;
        bit lv;
        logic [27:0] exp_v;
        start_measure();
        for (int w = 0; w < 2; w++) begin
            run_window(MODE_HIGH, 0, G, edges, early, lv);
            exp_v = model_pair(edges);
            n_cmp++;
            if (early != 0 || !lv) begin
                n_bad++;
                $display("FAIL held_high_valid[%0d]: got early=%0d last=%0b expected early=0 last=1", w, early, lv);
            end
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL held_high_result[%0d]: got %h expected %h", w, obs, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    task automatic test_rates();
        int periods[5];
        int edges, early;
        bit lv;
        logic [27:0] exp_v;
        periods[0] = 10;
        periods[1] = 50;
        periods[2] = 30;
        periods[3] = $urandom_range(120, 2);
        periods[4] = $urandom_range(40, 8);
        start_measure();
        foreach (periods[k]) begin
            run_window(MODE_PERIOD, periods[k], G, edges, early, lv);
            exp_v = model_pair(edges);
            n_cmp++;
            if (early != 0 || !lv) begin
                n_bad++;
                $display("FAIL rate_valid[p=%0d]: got early=%0d last=%0b expected early=0 last=1", periods[k], early, lv);
            end
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rate_result[p=%0d]: got %h expected %h", periods[k], obs, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    task automatic test_saturation();
        int edges, early;
        bit lv;
        logic [27:0] exp_v;
        start_measure();
        for (int w = 0; w < 2; w++) begin
            if (w == 0) run_window(MODE_PERIOD, 2, G, edges, early, lv);
            else        run_window(MODE_COUNT, 5, G, edges, early, lv);
            exp_v = model_pair(edges);
            n_cmp++;
            if (early != 0 || !lv) begin
                n_bad++;
                $display("FAIL sat_valid[%0d]: got early=%0d last=%0b expected early=0 last=1", w, early, lv);
            end
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL sat_result[%0d]: got %h expected %h", w, obs, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    // Drops run at gate cycle 'cut' (500 = mid-window, G-1 = the end-of-window cycle itself).
    task automatic test_abort(input int cut);
        int edges, early, valids;
        bit lv;
        logic [27:0] exp_v;
        start_measure();
        run_window(MODE_PERIOD, 10, cut, edges, early, lv);
        idle_cycles(20, valids);
        n_cmp++;
        if (early + valids != 0) begin
            n_bad++;
            $display("FAIL abort_no_valid[cut=%0d]: got %0d valids expected 0", cut, early + valids);
        end
        n_cmp++;
        if (obs !== last_exp) begin
            n_bad++;
            $display("FAIL abort_hold[cut=%0d]: got %h expected %h", cut, obs, last_exp);
        end
        start_measure();
        run_window(MODE_PERIOD, 30, G, edges, early, lv);
        exp_v = model_pair(edges);
        n_cmp++;
        if (early != 0 || !lv) begin
            n_bad++;
            $display("FAIL abort_restart_valid[cut=%0d]: got early=%0d last=%0b expected early=0 last=1", cut, early, lv);
        end
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL abort_restart_result[cut=%0d]: got %h expected %h", cut, obs, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_reset_mid_window();
        int edges, early;
        bit lv;
        logic [27:0] exp_v;
        start_measure();
        run_window(MODE_PERIOD, 10, 300, edges, early, lv);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs, bus10.valid, bus4.valid} !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_async_clear: got %h expected %h", {obs, bus10.valid, bus4.valid}, 30'd0);
        end
        @(posedge ckht);
        #1 rst_n = 1'b1;
        prev_ena  = 1'b0;
        measuring = 1'b0;
        last_exp  = '0;
        run       = 1'b0;
        start_measure();
        run_window(MODE_PERIOD, 50, G, edges, early, lv);
        exp_v = model_pair(edges);
        n_cmp++;
        if (early != 0 || !lv) begin
            n_bad++;
            $display("FAIL reset_restart_valid: got early=%0d last=%0b expected early=0 last=1", early, lv);
        end
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_restart_result: got %h expected %h", obs, exp_v);
        end
        last_exp = exp_v;
    endtask

    task automatic test_back_to_back();
        int edges, early, dens;
        bit lv;
        logic [27:0] exp_v;
        start_measure();
        for (int w = 0; w < 4; w++) begin
            dens = $urandom_range(60, 0);
            run_window(MODE_RAND, dens, G, edges, early, lv);
            exp_v = model_pair(edges);
            n_cmp++;
            if (early != 0 || !lv) begin
                n_bad++;
                $display("FAIL b2b_valid[%0d]: got early=%0d last=%0b expected early=0 last=1", w, early, lv);
            end
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_result[%0d,d=%0d]: got %h expected %h", w, dens, obs, exp_v);
            end
            last_exp = exp_v;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_held_high();
        test_rates();
        test_saturation();
        test_abort(500);
        test_abort(G - 1);
        test_reset_mid_window();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
